dense_25d_stream_ctrl: RTL
==========================

Name: dense_25d_stream_ctrl

Overview:
- Sequencer for one enable-gated dense_25D convolution datapath instance.
- Accepts a raster pixel stream over a valid/ready handshake and drives the datapath pixel input plus a shift/pipeline enable.
- Tracks which shift-register positions hold complete windows and flags each window result, with its coordinates, when it leaves the datapath pipeline.
- Flushes the pipeline at end of frame and signals completion.

Parameters:
DATA_W, 8, pixel width
P_SR_DEPTH, 4, window width in pixels (datapath shift-register depth)
NUM_SR_ROWS, 4, window height in rows
IMG_WIDTH, 8, pixels per image row
IMG_HEIGHT, 8, rows per frame
PIPE_LATENCY, 8, enabled steps from datapath pixel input to result (mult-adder tree 6 + Z tree 2)

Ports:
clock  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  frame start pulse; honoured only in IDLE
pix_in  in  DATA_W  incoming pixel
pix_in_valid  in  1  pix_in valid
pix_in_ready  out  1  controller accepts pix_in this cycle
dp_pixel  out  DATA_W  pixel to datapath pixel_vector_in (replicated by parent)
dp_en  out  1  advances datapath shift registers and pipeline one step
out_valid  out  1  datapath pixel_vector_out holds a valid window result this cycle
out_col  out  16  result window column, 0..IMG_WIDTH-P_SR_DEPTH
out_row  out  16  result window row, 0..IMG_HEIGHT-NUM_SR_ROWS
busy  out  1  high in LOAD and DRAIN
done  out  1  one-cycle pulse at end of frame
stall_count  out  16  see Optional Feature

Behaviour:
- Reset (synchronous, active-high) has priority over everything, including mid-frame.
  - Next state is IDLE.
  - All outputs, counters and the tag pipeline clear to 0.
  - No stale out_valid is allowed after reset.
- IDLE:
  - pix_in_ready=0, dp_en=0, busy=0.
  - start=1 moves to LOAD and clears the pixel counters.
- LOAD:
  - pix_in_ready=1.
  - Acceptance occurs when pix_in_valid & pix_in_ready; dp_en is combinationally equal to that acceptance, and dp_pixel=pix_in.
  - Input column counter c and row counter r advance on acceptance; c wraps at IMG_WIDTH-1 and r increments.
  - Each accepted pixel pushes tag = (r >= NUM_SR_ROWS-1) && (c >= P_SR_DEPTH-1) into a PIPE_LATENCY-deep tag shift register. That register advances only on dp_en.
  - When the last pixel (r=IMG_HEIGHT-1, c=IMG_WIDTH-1) is accepted, move to DRAIN.
- DRAIN:
  - pix_in_ready=0, dp_pixel=0, dp_en=1 every cycle, pushed tag=0.
  - Lasts exactly PIPE_LATENCY-1 cycles (down-counter), then move to DONE.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
- Result flagging:
  - out_valid is registered. It is 1 in cycle t+1 iff dp_en=1 in cycle t and the tag arriving at the tail position at that edge is 1.
  - With no input bubbles, a pixel accepted in cycle t gives out_valid in cycle t+PIPE_LATENCY.
  - Exactly one out_valid per valid window; order is raster order.
- out_col/out_row:
  - Separate output counters, updated on the edge after each out_valid.
  - out_col wraps at IMG_WIDTH-P_SR_DEPTH and then increments out_row.
  - They present the current result's coordinates while out_valid=1.
- Results per frame: (IMG_WIDTH-P_SR_DEPTH+1)*(IMG_HEIGHT-NUM_SR_ROWS+1); this is 25 for the defaults.
- start outside IDLE is ignored.
- start and reset in the same cycle: reset wins.
- Bubbles (pix_in_valid=0 in LOAD): dp_en=0, the datapath and tags hold, no out_valid is generated.
- Counter widths are 16 bits. IMG_WIDTH and IMG_HEIGHT must each be at most 65535, and PIPE_LATENCY at least 2.

Optional Feature:
- Macro DENSE_CTRL_STALL_CNT_EN.
- Defined:
  - stall_count counts LOAD cycles with pix_in_valid=0, saturating at 16'hFFFF.
  - Cleared on reset and on start accepted in IDLE.
  - Holds its value after DONE.
- Undefined: stall_count is tied to 0 and no counter logic is built.

Test Plan:
1. Reset check: hold reset 2 cycles with start=1 and pix_in_valid=1 → all outputs 0, pix_in_ready=0, no out_valid afterwards until a new start.
2. Continuous frame: start, stream pixels 0..63 with valid always high.
   - pix_in_ready is high for exactly 64 cycles.
   - First out_valid occurs 8 cycles after pixel 27 is accepted, with coords (0,0).
   - 25 out_valid pulses total; the last has coords (4,4).
   - busy is high for 64+7 cycles, then done is one pulse.
3. Bubbles: valid pattern 1,0,1,0...
   - dp_en mirrors acceptance.
   - Still 25 results in the same order with the same coords.
   - No out_valid without a preceding dp_en cycle.
4. start pulsed during LOAD at pixel 10 and during DRAIN → ignored; counts and done timing identical to scenario 2.
5. Reset asserted after pixel 40 → next cycle all outputs 0 and no further out_valid; a fresh start gives a full 25-result frame beginning at (0,0).
6. With DENSE_CTRL_STALL_CNT_EN, scenario 3 gives stall_count=63 after DONE; without the macro, stall_count=0 throughout.

Source files
------------

// File: rtl/dense_25d_stream_ctrl.sv
// dense_25d_stream_ctrl
// ---------------------
// Sequencer for one enable-gated dense_25D convolution datapath instance.
// It accepts a raster pixel stream, feeds the datapath one pixel per enabled
// step, and tracks which steps carry a complete window. When that window's
// result leaves the datapath pipeline it raises out_valid with the window's
// coordinates. At end of frame it flushes the pipeline and pulses done.
//
// Ports
//   clock, reset   single clock; synchronous active-high reset
//   start          frame start pulse, only acted on while idle
//   pix_in         incoming pixel; pix_in_valid / pix_in_ready handshake
//   dp_pixel       pixel driven into the datapath (zero while flushing)
//   dp_en          advances datapath shift registers and pipeline one step
//   out_valid      datapath output holds a valid window result this cycle
//   out_col/out_row coordinates of the result flagged by out_valid
//   busy           high while loading or flushing
//   done           one-cycle end-of-frame pulse
//   stall_count    LOAD cycles with no input offered (optional feature)
//
// Optional feature macro: DENSE_CTRL_STALL_CNT_EN
//   defined   -> stall_count is a saturating 16-bit stall counter
//   undefined -> stall_count is tied to 0
module dense_25d_stream_ctrl #(
    parameter int DATA_W       = 8,
    parameter int P_SR_DEPTH   = 4,
    parameter int NUM_SR_ROWS  = 4,
    parameter int IMG_WIDTH    = 8,
    parameter int IMG_HEIGHT   = 8,
    parameter int PIPE_LATENCY = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_in_valid,
    output logic              pix_in_ready,
    output logic [DATA_W-1:0] dp_pixel,
    output logic              dp_en,
    output logic              out_valid,
    output logic [15:0]       out_col,
    output logic [15:0]       out_row,
    output logic              busy,
    output logic              done,
    output logic [15:0]       stall_count
);

    // The out_valid flop acts as the final (tail) tag position, so the
    // explicit tag shift register only needs PIPE_LATENCY-1 stages.
    localparam int TAG_D = PIPE_LATENCY - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [15:0]      col_cnt;
    logic [15:0]      row_cnt;
    logic [15:0]      drain_cnt;
    logic [TAG_D-1:0] tag_sr;
    logic [TAG_D-1:0] tag_sr_next;
    logic             tag_in;
    logic             win_tag;
    logic             last_pix;
    logic             accept;
    logic             frame_start;

    assign win_tag  = (row_cnt >= 16'(NUM_SR_ROWS - 1)) && (col_cnt >= 16'(P_SR_DEPTH - 1));
    assign last_pix = (row_cnt == 16'(IMG_HEIGHT - 1)) && (col_cnt == 16'(IMG_WIDTH - 1));
    assign frame_start = (state == IDLE) && start;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pix_in_ready = 1'b0;
        dp_en        = 1'b0;
        dp_pixel     = '0;
        busy         = 1'b0;
        done         = 1'b0;
        tag_in       = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                pix_in_ready = 1'b1;
                busy         = 1'b1;
                accept       = pix_in_valid;
                dp_en        = pix_in_valid;
                dp_pixel     = pix_in;
                tag_in       = win_tag;
                if (pix_in_valid && last_pix) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy  = 1'b1;
                dp_en = 1'b1;
                if (drain_cnt == 16'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shifting left drops the oldest tag; written this way so a
    // single-stage register (PIPE_LATENCY=2) needs no special case.
    always_comb begin
        tag_sr_next    = tag_sr << 1;
        tag_sr_next[0] = tag_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            drain_cnt <= '0;
            tag_sr    <= '0;
            out_valid <= 1'b0;
            out_col   <= '0;
            out_row   <= '0;
        end else begin
            if (frame_start) begin
                col_cnt   <= '0;
                row_cnt   <= '0;
                drain_cnt <= '0;
                out_col   <= '0;
                out_row   <= '0;
            end

            if (accept) begin
                if (col_cnt == 16'(IMG_WIDTH - 1)) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 16'd1;
                end else begin
                    col_cnt <= col_cnt + 16'd1;
                end
            end

            // Flush length: after the last pixel, PIPE_LATENCY-1 more steps
            // bring its tag to the tail.
            if (accept && last_pix) begin
                drain_cnt <= 16'(PIPE_LATENCY - 2);
            end else if (state == DRAIN && drain_cnt != 16'd0) begin
                drain_cnt <= drain_cnt - 16'd1;
            end

            // Tags move only when the datapath moves, so bubbles hold both
            // in lockstep and never produce a result flag.
            if (dp_en) begin
                tag_sr    <= tag_sr_next;
                out_valid <= tag_sr[TAG_D-1];
            end else begin
                out_valid <= 1'b0;
            end

            // Coordinates advance after each flagged result so they name the
            // result currently on the output.
            if (out_valid) begin
                if (out_col == 16'(IMG_WIDTH - P_SR_DEPTH)) begin
                    out_col <= '0;
                    out_row <= out_row + 16'd1;
                end else begin
                    out_col <= out_col + 16'd1;
                end
            end
        end
    end

`ifdef DENSE_CTRL_STALL_CNT_EN
    logic [15:0] stall_q;

    // Counts LOAD cycles with no pixel offered; saturates and holds after
    // the frame so it can be read once the frame is done.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (frame_start) begin
            stall_q <= '0;
        end else if (state == LOAD && !pix_in_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule
